keyboard_voice_alloc: RTL and testbench

- Polyphonic successor to the single-key keycode-to-tone mapper.
- Takes a full USB HID boot-keyboard report of up to NUM_KEYS keycodes and detects key presses and releases against the previous report.
- Allocates each newly pressed key to one of NUM_VOICES tone-generator channels, and applies a saturating octave shift.
- Sits between the USB keyboard interface and the per-voice oscillator bank.

---
 rtl/keyboard_voice_alloc.sv | 170 +++++++++++++++++
 tb/tb_keyboard_voice_alloc.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/keyboard_voice_alloc.sv
// Polyphonic HID-report voice allocator: diffs each keyboard report against the held
// voices, releases missing keys, then assigns new table keys to free or stolen voices.
module keyboard_voice_alloc #(
  parameter int NUM_KEYS   = 6,
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 16
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [8*NUM_KEYS-1:0]        keycode_in,
  input  logic                         report_valid,
  input  logic                         octave_up,
  input  logic                         octave_down,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [8*NUM_VOICES-1:0]      voice_key,
  output logic signed [2:0]            octave,
  output logic                         busy
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(NUM_KEYS + NUM_VOICES);
  localparam logic [CW-1:0] LAST_V  = CW'(NUM_VOICES - 1);
  localparam logic [CW-1:0] LAST_K  = CW'(NUM_KEYS - 1);
  localparam logic [VW-1:0] LAST_VP = VW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, REL, PRS} state_t;

  state_t                                r_state, w_nxt;
  logic [CW-1:0]                         r_idx;
  logic [NUM_KEYS-1:0][7:0]              r_rep, r_pend;
  logic                                  r_pend_vld;
  logic [NUM_VOICES-1:0][7:0]            r_key;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]     r_note;
  logic [NUM_VOICES-1:0]                 r_gate;
  logic signed [2:0]                     r_oct;
  logic [VW-1:0]                         r_steal;

  // {hit, base tone word}; unknown keycodes miss
  function automatic logic [10:0] tone_base(input logic [7:0] kc);
    case (kc)
      8'd53: tone_base = {1'b1, 10'h083};  8'd30: tone_base = {1'b1, 10'h08B};
      8'd31: tone_base = {1'b1, 10'h093};  8'd32: tone_base = {1'b1, 10'h09C};
      8'd33: tone_base = {1'b1, 10'h0A5};  8'd34: tone_base = {1'b1, 10'h0AF};
      8'd35: tone_base = {1'b1, 10'h0B9};  8'd36: tone_base = {1'b1, 10'h0C4};
      8'd37: tone_base = {1'b1, 10'h0D0};  8'd38: tone_base = {1'b1, 10'h0DC};
      8'd39: tone_base = {1'b1, 10'h0E9};  8'd45: tone_base = {1'b1, 10'h0F7};
      8'd43: tone_base = {1'b1, 10'h106};  8'd20: tone_base = {1'b1, 10'h115};
      8'd26: tone_base = {1'b1, 10'h126};  8'd8:  tone_base = {1'b1, 10'h137};
      8'd21: tone_base = {1'b1, 10'h14A};  8'd23: tone_base = {1'b1, 10'h15D};
      8'd28: tone_base = {1'b1, 10'h172};  8'd24: tone_base = {1'b1, 10'h188};
      8'd12: tone_base = {1'b1, 10'h19F};  8'd18: tone_base = {1'b1, 10'h1B8};
      8'd19: tone_base = {1'b1, 10'h1D2};  8'd47: tone_base = {1'b1, 10'h1EE};
      8'd57: tone_base = {1'b1, 10'h20B};  8'd4:  tone_base = {1'b1, 10'h22A};
      8'd22: tone_base = {1'b1, 10'h24B};  8'd7:  tone_base = {1'b1, 10'h26E};
      8'd9:  tone_base = {1'b1, 10'h293};  8'd10: tone_base = {1'b1, 10'h2BA};
      8'd11: tone_base = {1'b1, 10'h2E4};  8'd13: tone_base = {1'b1, 10'h310};
      8'd14: tone_base = {1'b1, 10'h33F};  8'd15: tone_base = {1'b1, 10'h370};
      8'd51: tone_base = {1'b1, 10'h3A4};  8'd52: tone_base = {1'b1, 10'h3DC};
      default: tone_base = '0;
    endcase
  endfunction

  logic                  w_err, w_in_rep, w_rel, w_held, w_free, w_alloc, w_hit;
  logic [7:0]            w_cur;
  logic [VW-1:0]         w_vsel, w_free_idx, w_tgt;
  logic [NOTE_W-1:0]     w_ext, w_tone;
  logic [10:0]           w_tb;

  assign w_vsel = r_idx[VW-1:0];

  always_comb begin
    w_err = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (keycode_in[8*k +: 8] == 8'h01) w_err = 1'b1;
    w_in_rep = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (r_rep[k] == r_key[w_vsel]) w_in_rep = 1'b1;
    w_rel = (r_key[w_vsel] != 8'h00) && !w_in_rep;
    w_cur = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (r_idx == CW'(k)) w_cur = r_rep[k];
    w_held = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (r_key[v] == w_cur) w_held = 1'b1;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--)
      if (r_key[v] == 8'h00) begin
        w_free     = 1'b1;
        w_free_idx = VW'(v);
      end
    w_tgt   = w_free ? w_free_idx : r_steal;
    w_tb    = tone_base(w_cur);
    w_hit   = w_tb[10];
    w_alloc = (w_cur != 8'h00) && w_hit && !w_held;
    w_ext   = NOTE_W'(w_tb[9:0]);
    case (r_oct)
      3'sd1:   w_tone = w_ext << 1;
      3'sd2:   w_tone = w_ext << 2;
      -3'sd1:  w_tone = w_ext >> 1;
      -3'sd2:  w_tone = w_ext >> 2;
      default: w_tone = w_ext;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if ((report_valid && !w_err) || r_pend_vld) w_nxt = REL;
      REL:     if (r_idx == LAST_V) w_nxt = PRS;
      PRS:     if (r_idx == LAST_K) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_idx <= '0; r_rep <= '0; r_pend <= '0; r_pend_vld <= 1'b0;
      r_key <= '0; r_note <= '0; r_gate <= '0; r_oct <= '0; r_steal <= '0;
    end else begin
      if (octave_up && !octave_down && r_oct != 3'sd2)        r_oct <= r_oct + 3'sd1;
      else if (octave_down && !octave_up && r_oct != -3'sd2)  r_oct <= r_oct - 3'sd1;
      // reports arriving mid-scan park here; only the newest survives
      if (r_state != IDLE && report_valid && !w_err) begin
        r_pend     <= keycode_in;
        r_pend_vld <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (report_valid && !w_err) begin
            r_rep      <= keycode_in;
            r_pend_vld <= 1'b0;
          end else if (r_pend_vld) begin
            r_rep      <= r_pend;
            r_pend_vld <= 1'b0;
          end
        end
        REL: begin
          r_idx <= (r_idx == LAST_V) ? '0 : r_idx + 1'b1;
          if (w_rel) begin
            r_gate[w_vsel] <= 1'b0;
            r_key[w_vsel]  <= '0;
          end
        end
        PRS: begin
          r_idx <= (r_idx == LAST_K) ? '0 : r_idx + 1'b1;
          if (w_alloc) begin
            r_key[w_tgt]  <= w_cur;
            r_note[w_tgt] <= w_tone;
            r_gate[w_tgt] <= 1'b1;
            if (!w_free) r_steal <= (r_steal == LAST_VP) ? '0 : r_steal + 1'b1;
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign voice_note = r_note;
  assign voice_gate = r_gate;
  assign voice_key  = r_key;
  assign octave     = r_oct;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_keyboard_voice_alloc.sv
// Directed bench for keyboard_voice_alloc: table of reports with hand-computed
// voice state, plus octave, back-to-back and mid-scan reset sequences.
module tb_keyboard_voice_alloc;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [47:0] keycode_in;
  logic        report_valid, octave_up, octave_down;
  logic [63:0] voice_note;
  logic [3:0]  voice_gate;
  logic [31:0] voice_key;
  logic signed [2:0] octave;
  logic        busy;

  keyboard_voice_alloc dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode_in(keycode_in), .report_valid(report_valid),
    .octave_up(octave_up), .octave_down(octave_down), .voice_note(voice_note),
    .voice_gate(voice_gate), .voice_key(voice_key), .octave(octave), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [47:0] rep);
    @(negedge Clk);
    keycode_in   = rep;
    report_valid = 1'b1;
    @(negedge Clk);
    report_valid = 1'b0;
  endtask

  // counts busy cycles from the current negedge until busy drops (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic pulse(input logic up, input logic dn);
    @(negedge Clk);
    octave_up = up; octave_down = dn;
    @(negedge Clk);
    octave_up = 1'b0; octave_down = 1'b0;
  endtask

  typedef struct {
    logic [47:0] rep;
    bit          scan;
    logic [31:0] key;
    logic [3:0]  gate;
    logic [63:0] note;
  } vec_t;

  vec_t tv[9];
  int   n;

  initial begin
    tv[0] = '{48'h0000_0000_0004, 1'b1, 32'h0000_0004, 4'b0001, 64'h0000_0000_0000_022A};
    tv[1] = '{48'h0000_0000_1604, 1'b1, 32'h0000_1604, 4'b0011, 64'h0000_0000_024B_022A};
    tv[2] = '{48'h0000_0000_0016, 1'b1, 32'h0000_1600, 4'b0010, 64'h0000_0000_024B_022A};
    tv[3] = '{48'h0000_0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 64'h0000_0000_024B_022A};
    tv[4] = '{48'h0022_2120_1F1E, 1'b1, 32'h2120_1F22, 4'b1111, 64'h00A5_009C_0093_00AF};
    tv[5] = '{48'h0023_2221_201F, 1'b1, 32'h2120_2322, 4'b1111, 64'h00A5_009C_00B9_00AF};
    tv[6] = '{48'h0000_0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 64'h00A5_009C_00B9_00AF};
    tv[7] = '{48'h0000_0001_0E0E, 1'b0, 32'h0000_0000, 4'b0000, 64'h00A5_009C_00B9_00AF};
    tv[8] = '{48'h0000_0000_0E0E, 1'b1, 32'h0000_000E, 4'b0001, 64'h00A5_009C_00B9_033F};

    Reset_n = 1'b0; keycode_in = '0; report_valid = 1'b0;
    octave_up = 1'b0; octave_down = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_note", voice_note, 64'h0);
    chk("rst_gate", {60'd0, voice_gate}, 64'h0);
    chk("rst_key", {32'd0, voice_key}, 64'h0);
    chk("rst_oct", {61'd0, octave}, 64'h0);
    chk("rst_busy", {63'd0, busy}, 64'h0);

    for (int i = 0; i < 9; i++) begin
      strobe(tv[i].rep);
      wait_idle(n);
      chk($sformatf("v%0d_busy_cycles", i), 64'(n), tv[i].scan ? 64'd10 : 64'd0);
      chk($sformatf("v%0d_key", i), {32'd0, voice_key}, {32'd0, tv[i].key});
      chk($sformatf("v%0d_gate", i), {60'd0, voice_gate}, {60'd0, tv[i].gate});
      chk($sformatf("v%0d_note", i), voice_note, tv[i].note);
    end

    // octave saturation; held voice keeps its word
    repeat (3) pulse(1'b1, 1'b0);
    chk("oct_sat_hi", {61'd0, octave}, {61'd0, 3'b010});
    pulse(1'b1, 1'b1);
    chk("oct_both", {61'd0, octave}, {61'd0, 3'b010});
    chk("held_note", {48'd0, voice_note[15:0]}, 64'h033F);
    strobe(48'h35);
    wait_idle(n);
    chk("oct_hi_key", {56'd0, voice_key[7:0]}, 64'h35);
    chk("oct_hi_note", {48'd0, voice_note[15:0]}, 64'h020C);
    repeat (5) pulse(1'b0, 1'b1);
    chk("oct_sat_lo", {61'd0, octave}, {61'd0, 3'b110});
    strobe(48'h34);
    wait_idle(n);
    chk("oct_lo_key", {32'd0, voice_key}, 64'h34);
    chk("oct_lo_note", {48'd0, voice_note[15:0]}, 64'h00F7);

    // back-to-back reports: first and last scanned, middle dropped
    @(negedge Clk); Reset_n = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    keycode_in = 48'h04; report_valid = 1'b1;
    @(negedge Clk); keycode_in = 48'h16;
    @(negedge Clk); keycode_in = 48'h1E;
    @(negedge Clk); report_valid = 1'b0;
    wait_idle(n);
    chk("b2b_first_key", {32'd0, voice_key}, 64'h04);
    @(negedge Clk);
    chk("b2b_restart", {63'd0, busy}, 64'd1);
    wait_idle(n);
    chk("b2b_second_cycles", 64'(n), 64'd10);
    chk("b2b_key", {32'd0, voice_key}, 64'h1E);
    chk("b2b_gate", {60'd0, voice_gate}, 64'h1);
    chk("b2b_note", {48'd0, voice_note[15:0]}, 64'h008B);
    repeat (3) @(negedge Clk);
    chk("b2b_no_third", {63'd0, busy}, 64'd0);

    // reset during PRS
    pulse(1'b1, 1'b0);
    strobe(48'h0000_0000_0016);
    repeat (5) @(negedge Clk);
    chk("mid_prs_busy", {63'd0, busy}, 64'd1);
    chk("mid_prs_key", {32'd0, voice_key}, 64'h16);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_key", {32'd0, voice_key}, 64'h0);
    chk("mr_gate", {60'd0, voice_gate}, 64'h0);
    chk("mr_note", voice_note, 64'h0);
    chk("mr_oct", {61'd0, octave}, 64'h0);
    repeat (3) @(negedge Clk);
    chk("mr_stays_idle", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
